// File: rtl/riscv_encoder.sv
// riscv_encoder
//   Assembles RV32I instruction words from decoded fields. It checks each word for
//   legality and buffers it in a small circular queue. Valid/ready handshakes are
//   used on both the input and output sides. Running counts of popped words (ok and
//   erroneous) saturate at all-ones.
// Ports
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   flush_i                      synchronous queue clear (counters kept)
//   valid_i / ready_o            field-set handshake (ready_o = queue not full)
//   format_i                     0=R 1=I 2=S 3=B 4=U 5=J, others invalid
//   op_i, funct_3_i, funct_7_i   opcode / function fields
//   rd_i, rs1_i, rs2_i           register indices
//   imm_i                        immediate (U: full 32-bit upper value)
//   valid_o / ready_i            queue-head handshake
//   instr_o, err_o               head word and status (0 ok, 1 format, 2 range, 3 align)
//   cnt_ok_o, cnt_err_o          saturating counts of popped ok / erroneous words
module riscv_encoder #(
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned STRICT_IMM = 1,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [2:0]       format_i,
  input  logic [6:0]       op_i,
  input  logic [2:0]       funct_3_i,
  input  logic [6:0]       funct_7_i,
  input  logic [4:0]       rd_i,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [31:0]      imm_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [31:0]      instr_o,
  output logic [1:0]       err_o,
  output logic [CNT_W-1:0] cnt_ok_o,
  output logic [CNT_W-1:0] cnt_err_o
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [2:0] {
    FMT_R = 3'd0,
    FMT_I = 3'd1,
    FMT_S = 3'd2,
    FMT_B = 3'd3,
    FMT_U = 3'd4,
    FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_OK    = 2'd0,
    ERR_FMT   = 2'd1,
    ERR_RANGE = 2'd2,
    ERR_ALIGN = 2'd3
  } err_e;

  fmt_e        fmt;
  logic [31:0] enc_instr;
  err_e        enc_err;
  logic        bad_fmt;
  logic        misaligned;
  logic        out_of_range;

  logic [31:0]   instr_q [DEPTH];
  err_e          err_q   [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          push;
  logic          pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Encoding and legality check
  always_comb begin
    enc_instr    = '0;
    bad_fmt      = 1'b0;
    misaligned   = 1'b0;
    out_of_range = 1'b0;
    fmt          = fmt_e'(format_i);
    case (fmt)
      FMT_R: enc_instr = {funct_7_i, rs2_i, rs1_i, funct_3_i, rd_i, op_i};
      FMT_I: begin
        enc_instr    = {imm_i[11:0], rs1_i, funct_3_i, rd_i, op_i};
        out_of_range = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_S: begin
        enc_instr    = {imm_i[11:5], rs2_i, rs1_i, funct_3_i, imm_i[4:0], op_i};
        out_of_range = !((&imm_i[31:11]) || !(|imm_i[31:11]));
      end
      FMT_B: begin
        enc_instr    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct_3_i,
                        imm_i[4:1], imm_i[11], op_i};
        misaligned   = imm_i[0];
        out_of_range = !((&imm_i[31:12]) || !(|imm_i[31:12]));
      end
      FMT_U: begin
        enc_instr    = {imm_i[31:12], rd_i, op_i};
        out_of_range = |imm_i[11:0];
      end
      FMT_J: begin
        enc_instr    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
        misaligned   = imm_i[0];
        out_of_range = !((&imm_i[31:20]) || !(|imm_i[31:20]));
      end
      default: bad_fmt = 1'b1;
    endcase

    enc_err = ERR_OK;
    if (bad_fmt)
      enc_err = ERR_FMT;
    else if (misaligned)
      enc_err = ERR_ALIGN;
    else if ((STRICT_IMM != 0) && out_of_range)
      enc_err = ERR_RANGE;
  end

  assign ready_o = (count < CW'(DEPTH));
  assign valid_o = (count != '0);
  assign push    = valid_i && ready_o && !flush_i;
  assign pop     = valid_o && ready_i;
  assign instr_o = valid_o ? instr_q[rd_ptr] : '0;
  assign err_o   = valid_o ? err_q[rd_ptr] : ERR_OK;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      cnt_ok_o  <= '0;
      cnt_err_o <= '0;
    end else begin
      // A pop in a flush cycle has already been handed to the consumer, so it is counted.
      if (pop) begin
        if (err_q[rd_ptr] == ERR_OK) begin
          if (cnt_ok_o != '1) cnt_ok_o <= cnt_ok_o + 1'b1;
        end else begin
          if (cnt_err_o != '1) cnt_err_o <= cnt_err_o + 1'b1;
        end
      end
      if (flush_i) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= ptr_next(wr_ptr);
        if (pop)  rd_ptr <= ptr_next(rd_ptr);
        if (push && !pop)
          count <= count + 1'b1;
        else if (pop && !push)
          count <= count - 1'b1;
      end
    end
  end

  // Storage needs no reset: the head is masked by valid_o.
  always_ff @(posedge clk_i) begin
    if (push) begin
      instr_q[wr_ptr] <= enc_instr;
      err_q[wr_ptr]   <= enc_err;
    end
  end

endmodule

// File: tb/tb_riscv_encoder.sv
module tb_riscv_encoder;

  logic        clk = 1'b0;
  logic        rst_i, flush_i, valid_i, ready_i;
  logic [2:0]  format_i, funct_3_i;
  logic [6:0]  op_i, funct_7_i;
  logic [4:0]  rd_i, rs1_i, rs2_i;
  logic [31:0] imm_i;

  logic        ready_o, valid_o;
  logic [31:0] instr_o;
  logic [1:0]  err_o;
  logic [15:0] cnt_ok_o, cnt_err_o;

  logic        ready_ns, valid_ns;
  logic [31:0] instr_ns;
  logic [1:0]  err_ns;
  logic [2:0]  cnt_ok_ns, cnt_err_ns;

  int checks = 0;
  int errors = 0;
  int m_ok = 0, m_err = 0, m_ok_ns = 0, m_err_ns = 0;

  always #5 clk = ~clk;

  riscv_encoder #(.DEPTH(2), .STRICT_IMM(1), .CNT_W(16)) dut (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_o),
    .format_i(format_i), .op_i(op_i), .funct_3_i(funct_3_i), .funct_7_i(funct_7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .valid_o(valid_o), .ready_i(ready_i), .instr_o(instr_o), .err_o(err_o),
    .cnt_ok_o(cnt_ok_o), .cnt_err_o(cnt_err_o));

  riscv_encoder #(.DEPTH(2), .STRICT_IMM(0), .CNT_W(3)) dut_ns (
    .clk_i(clk), .rst_i(rst_i), .flush_i(flush_i), .valid_i(valid_i), .ready_o(ready_ns),
    .format_i(format_i), .op_i(op_i), .funct_3_i(funct_3_i), .funct_7_i(funct_7_i),
    .rd_i(rd_i), .rs1_i(rs1_i), .rs2_i(rs2_i), .imm_i(imm_i),
    .valid_o(valid_ns), .ready_i(ready_i), .instr_o(instr_ns), .err_o(err_ns),
    .cnt_ok_o(cnt_ok_ns), .cnt_err_o(cnt_err_ns));

  typedef struct {
    logic [2:0]  fmt;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic [31:0] exp_instr;
    logic [1:0]  exp_err;
    logic [1:0]  exp_err_ns;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  err;
    logic [1:0]  err_ns;
  } sb_t;

  sb_t sb[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic int sat(input int n, input int w);
    return (n > (1 << w) - 1) ? (1 << w) - 1 : n;
  endfunction

  // Reference encoder: fields placed by shift/mask, ranges checked as signed intervals.
  function automatic logic [33:0] model(input logic [2:0] fmt, input logic [6:0] op,
      input logic [2:0] f3, input logic [6:0] f7, input logic [4:0] rd,
      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm, input bit strict);
    bit [31:0] OP = op, F3 = f3, F7 = f7, RD = rd, RS1 = rs1, RS2 = rs2, IM = imm;
    int s = signed'(imm);
    bit [31:0] w = 0;
    bit range_bad = 0, align_bad = 0, fmt_bad = 0;
    logic [1:0] e;
    case (fmt)
      3'd0: w = (F7 << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | OP;
      3'd1: begin
        w = ((IM & 32'hFFF) << 20) | (RS1 << 15) | (F3 << 12) | (RD << 7) | OP;
        range_bad = (s < -2048) || (s > 2047);
      end
      3'd2: begin
        w = (((IM >> 5) & 32'h7F) << 25) | (RS2 << 20) | (RS1 << 15) | (F3 << 12)
          | ((IM & 32'h1F) << 7) | OP;
        range_bad = (s < -2048) || (s > 2047);
      end
      3'd3: begin
        w = (((IM >> 12) & 1) << 31) | (((IM >> 5) & 32'h3F) << 25) | (RS2 << 20)
          | (RS1 << 15) | (F3 << 12) | (((IM >> 1) & 32'hF) << 8) | (((IM >> 11) & 1) << 7) | OP;
        range_bad = (s < -4096) || (s > 4095);
        align_bad = IM[0];
      end
      3'd4: begin
        w = (IM & 32'hFFFFF000) | (RD << 7) | OP;
        range_bad = (IM % 4096) != 0;
      end
      3'd5: begin
        w = (((IM >> 20) & 1) << 31) | (((IM >> 1) & 32'h3FF) << 21) | (((IM >> 11) & 1) << 20)
          | (((IM >> 12) & 32'hFF) << 12) | (RD << 7) | OP;
        range_bad = (s < -(1 << 20)) || (s > (1 << 20) - 1);
        align_bad = IM[0];
      end
      default: fmt_bad = 1;
    endcase
    e = fmt_bad ? 2'd1 : align_bad ? 2'd3 : (strict && range_bad) ? 2'd2 : 2'd0;
    return {e, w};
  endfunction

  task automatic set_fields(input logic [2:0] fmt, input logic [6:0] op, input logic [2:0] f3,
      input logic [6:0] f7, input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic [31:0] imm);
    format_i = fmt; op_i = op; funct_3_i = f3; funct_7_i = f7;
    rd_i = rd; rs1_i = rs1; rs2_i = rs2; imm_i = imm;
  endtask

  task automatic set_r(input logic [4:0] rd);
    set_fields(3'd0, 7'h33, 3'd0, 7'd0, rd, 5'd1, 5'd2, 32'd0);
  endtask

  function automatic logic [31:0] r_word(input logic [4:0] rd);
    logic [33:0] m = model(3'd0, 7'h33, 3'd0, 7'd0, rd, 5'd1, 5'd2, 32'd0, 1'b1);
    return m[31:0];
  endfunction

  task automatic chk_counters(input string tag);
    chk({tag, "_cnt_ok"}, 32'(cnt_ok_o), 32'(sat(m_ok, 16)));
    chk({tag, "_cnt_err"}, 32'(cnt_err_o), 32'(sat(m_err, 16)));
    chk({tag, "_cnt_ok_ns"}, 32'(cnt_ok_ns), 32'(sat(m_ok_ns, 3)));
    chk({tag, "_cnt_err_ns"}, 32'(cnt_err_ns), 32'(sat(m_err_ns, 3)));
  endtask

  task automatic drive_rand();
    logic [31:0] imm;
    int mode = $urandom_range(0, 3);
    case (mode)
      0: imm = 32'($urandom_range(0, 8191)) - 32'd4096;
      1: imm = $urandom;
      2: imm = $urandom & 32'hFFFFF000;
      default: imm = 32'($urandom_range(0, (1 << 21) - 1)) - 32'(1 << 20);
    endcase
    if ($urandom_range(0, 1) == 1) imm[0] = 1'b0;
    set_fields(($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5)),
               7'($urandom), 3'($urandom), 7'($urandom), 5'($urandom), 5'($urandom),
               5'($urandom), imm);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_valid"}, 32'(valid_o), 32'(sb.size() != 0));
    chk({tag, "_ready"}, 32'(ready_o), 32'(sb.size() < 2));
    chk({tag, "_valid_ns"}, 32'(valid_ns), 32'(sb.size() != 0));
    if (sb.size() != 0) begin
      chk({tag, "_instr"}, instr_o, sb[0].instr);
      chk({tag, "_err"}, 32'(err_o), 32'(sb[0].err));
      chk({tag, "_instr_ns"}, instr_ns, sb[0].instr);
      chk({tag, "_err_ns"}, 32'(err_ns), 32'(sb[0].err_ns));
    end
    chk_counters(tag);
  endtask

  vec_t tbl[10];

  initial begin
    int acc;
    logic [33:0] m;
    bit push, pop;
    sb_t e;

    tbl[0] = '{3'd0, 7'h33, 3'd0, 7'd0, 5'd3, 5'd1, 5'd2, 32'd0,          32'h002081B3, 2'd0, 2'd0};
    tbl[1] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'hFFFFFFFF,   32'hFFF00093, 2'd0, 2'd0};
    tbl[2] = '{3'd2, 7'h23, 3'd2, 7'd0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h0020A423, 2'd0, 2'd0};
    tbl[3] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd16,         32'h00000863, 2'd0, 2'd0};
    tbl[4] = '{3'd5, 7'h6F, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800,        32'h001000EF, 2'd0, 2'd0};
    tbl[5] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7, 2'd0, 2'd0};
    tbl[6] = '{3'd3, 7'h63, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd3,          32'h00000163, 2'd3, 2'd3};
    tbl[7] = '{3'd1, 7'h13, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'h800,        32'h80000093, 2'd2, 2'd0};
    tbl[8] = '{3'd6, 7'h33, 3'd1, 7'd5, 5'd7, 5'd8, 5'd9, 32'h1234,       32'h00000000, 2'd1, 2'd1};
    tbl[9] = '{3'd4, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'h123,        32'h00000037, 2'd2, 2'd0};

    rst_i = 1'b1; flush_i = 1'b0; valid_i = 1'b0; ready_i = 1'b0;
    set_fields(3'd0, 7'd0, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
    #12;
    chk("rst_valid", 32'(valid_o), 32'd0);
    chk("rst_instr", instr_o, 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk_counters("rst");
    @(negedge clk);
    rst_i = 1'b0;
    @(negedge clk);
    chk("rel_ready", 32'(ready_o), 32'd1);
    chk("rel_valid", 32'(valid_o), 32'd0);

    // Directed single words, each checked one cycle after its push.
    for (int i = 0; i < 10; i++) begin
      set_fields(tbl[i].fmt, tbl[i].op, tbl[i].f3, tbl[i].f7, tbl[i].rd, tbl[i].rs1,
                 tbl[i].rs2, tbl[i].imm);
      valid_i = 1'b1; ready_i = 1'b1;
      @(negedge clk);
      valid_i = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(valid_o), 32'd1);
      chk($sformatf("vec%0d_instr", i), instr_o, tbl[i].exp_instr);
      chk($sformatf("vec%0d_err", i), 32'(err_o), 32'(tbl[i].exp_err));
      chk($sformatf("vec%0d_instr_ns", i), instr_ns, tbl[i].exp_instr);
      chk($sformatf("vec%0d_err_ns", i), 32'(err_ns), 32'(tbl[i].exp_err_ns));
      if (tbl[i].exp_err == 0) m_ok++; else m_err++;
      if (tbl[i].exp_err_ns == 0) m_ok_ns++; else m_err_ns++;
    end
    @(negedge clk);
    ready_i = 1'b0;
    chk("tbl_drained", 32'(valid_o), 32'd0);
    chk_counters("tbl");

    // Backpressure: three pushes into a two-entry queue, then in-order drain.
    acc = 0;
    for (int k = 0; k < 3; k++) begin
      set_r(5'(k + 1));
      valid_i = 1'b1;
      if (ready_o) acc++;
      @(negedge clk);
    end
    valid_i = 1'b0;
    chk("bp_accepted", 32'(acc), 32'd2);
    chk("bp_ready_low", 32'(ready_o), 32'd0);
    for (int k = 0; k < 2; k++) begin
      chk("bp_head_held", instr_o, r_word(5'd1));
      @(negedge clk);
    end
    ready_i = 1'b1;
    chk("bp_drain0", instr_o, r_word(5'd1));
    @(negedge clk);
    chk("bp_drain1", instr_o, r_word(5'd2));
    @(negedge clk);
    ready_i = 1'b0;
    chk("bp_empty", 32'(valid_o), 32'd0);
    m_ok += 2; m_ok_ns += 2;
    chk_counters("bp");

    // Flush with a full queue, then flush racing a push into a half-full queue.
    for (int k = 0; k < 2; k++) begin
      set_r(5'(k + 10));
      valid_i = 1'b1;
      @(negedge clk);
    end
    valid_i = 1'b0;
    chk("fl_full", 32'(ready_o), 32'd0);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0;
    chk("fl_valid", 32'(valid_o), 32'd0);
    chk("fl_ready", 32'(ready_o), 32'd1);
    chk_counters("fl");
    set_r(5'd20);
    valid_i = 1'b1;
    @(negedge clk);
    set_r(5'd21);
    flush_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("fl_push_dropped", 32'(valid_o), 32'd0);
    @(negedge clk);
    chk("fl_still_empty", 32'(valid_o), 32'd0);

    // Randomized traffic against the scoreboard.
    sb.delete();
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      check_outputs("rnd");
      ready_i = ($urandom_range(0, 99) < 60);
      valid_i = ($urandom_range(0, 99) < 60);
      flush_i = !ready_i && ($urandom_range(0, 99) < 5);
      drive_rand();
      push = valid_i && !flush_i && (sb.size() < 2);
      pop  = (sb.size() != 0) && ready_i;
      if (pop) begin
        e = sb.pop_front();
        if (e.err == 0) m_ok++; else m_err++;
        if (e.err_ns == 0) m_ok_ns++; else m_err_ns++;
      end
      if (flush_i) sb.delete();
      else if (push) begin
        m = model(format_i, op_i, funct_3_i, funct_7_i, rd_i, rs1_i, rs2_i, imm_i, 1'b1);
        e.instr = m[31:0];
        e.err = m[33:32];
        m = model(format_i, op_i, funct_3_i, funct_7_i, rd_i, rs1_i, rs2_i, imm_i, 1'b0);
        e.err_ns = m[33:32];
        sb.push_back(e);
      end
    end
    @(negedge clk);
    check_outputs("rnd_end");

    // Asynchronous reset while a word is queued and another is being pushed.
    flush_i = 1'b0; ready_i = 1'b0;
    set_r(5'd30);
    valid_i = 1'b1;
    @(negedge clk);
    set_r(5'd31);
    #2 rst_i = 1'b1;
    #1;
    chk("arst_valid", 32'(valid_o), 32'd0);
    chk("arst_instr", instr_o, 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    m_ok = 0; m_err = 0; m_ok_ns = 0; m_err_ns = 0;
    chk_counters("arst");
    @(negedge clk);
    valid_i = 1'b0;
    rst_i = 1'b0;
    @(negedge clk);
    chk("arst_rel_valid", 32'(valid_o), 32'd0);
    chk("arst_rel_ready", 32'(ready_o), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
